// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: a small in-order buffer of pending register writes
// between the ALU and the register file, plus the architectural N/Z flags.
module alu_writeback_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  input  logic        zero,
  input  logic        negative,
  input  logic [3:0]  dest_reg,
  input  logic        reg_write,
  input  logic        set_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        flag_n,
  output logic        flag_z,
  input  logic [3:0]  hz_reg,
  output logic        hz_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          flag_n_r;
  logic          flag_z_r;
  logic [3:0]    ent_reg_r  [DEPTH];
  logic [31:0]   ent_data_r [DEPTH];

  logic          drain_s;
  logic          accept_s;
  logic          write_s;
  logic          hz_hit_s;
  logic [PW-1:0] off_s;

  assign wb_valid   = (count_r != {CW{1'b0}});
  assign drain_s    = wb_valid && wb_ready;
  // A full buffer still takes a new operation when the head leaves this cycle.
  assign in_ready   = (count_r < CW'(DEPTH)) || drain_s;
  assign accept_s   = in_valid && in_ready;
  assign write_s    = accept_s && reg_write;
  assign wb_reg     = ent_reg_r[head_r];
  assign wb_data    = ent_data_r[head_r];
  assign flag_n     = flag_n_r;
  assign flag_z     = flag_z_r;
  assign hz_pending = hz_hit_s;

  // Occupancy update from simultaneous write and drain.
  always_comb begin
    count_nxt_s = count_r;
    case ({write_s, drain_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Hazard lookup: an entry is live when its distance from head is below count.
  always_comb begin
    hz_hit_s = 1'b0;
    off_s    = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off_s = PW'(i) - head_r;
      if ((CW'(off_s) < count_r) && (ent_reg_r[i] == hz_reg)) begin
        hz_hit_s = 1'b1;
      end else begin
        hz_hit_s = hz_hit_s;
      end
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (write_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (drain_s) begin
        head_r <= head_r + PW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Architectural flags follow every accepted flag-setting operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_n_r <= 1'b0;
      flag_z_r <= 1'b0;
    end else if (accept_s && set_flags) begin
      flag_n_r <= negative;
      flag_z_r <= zero;
    end
  end

  // Entry storage carries no reset; liveness comes from head/count alone.
  always_ff @(posedge clk) begin
    if (write_s) begin
      ent_reg_r[tail_r]  <= dest_reg;
      ent_data_r[tail_r] <= result;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: directed scenarios then random traffic.
module tb_alu_writeback_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic [3:0]  dest_reg;
  logic        reg_write;
  logic        set_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flag_n;
  logic        flag_z;
  logic [3:0]  hz_reg;
  logic        hz_pending;

  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  logic m_n;
  logic m_z;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  always #5 clk = ~clk;

  alu_writeback_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .zero(zero), .negative(negative), .dest_reg(dest_reg),
    .reg_write(reg_write), .set_flags(set_flags), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data), .flag_n(flag_n),
    .flag_z(flag_z), .hz_reg(hz_reg), .hz_pending(hz_pending)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare pre-edge outputs, then advance the model.
  task automatic cycle(input logic v, input logic rw, input logic sf, input logic z,
                       input logic n, input logic [3:0] dr, input logic [31:0] res,
                       input logic wr_rdy, input logic [3:0] hz);
    logic exp_rdy, acc, drn, hzp;
    ent_t tmp;
    in_valid = v; reg_write = rw; set_flags = sf; zero = z; negative = n;
    dest_reg = dr; result = res; wb_ready = wr_rdy; hz_reg = hz;
    #1;
    exp_rdy = (q.size() < DEPTH) || ((q.size() != 0) && wr_rdy);
    check_val("wb_valid", 32'(wb_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_val("wb_reg", 32'(wb_reg), 32'(q[0].r));
      check_val("wb_data", wb_data, q[0].d);
    end
    check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_val("flag_n", 32'(flag_n), 32'(m_n));
    check_val("flag_z", 32'(flag_z), 32'(m_z));
    hzp = 1'b0;
    foreach (q[i]) if (q[i].r == hz) hzp = 1'b1;
    check_val("hz_pending", 32'(hz_pending), 32'(hzp));
    acc = v && exp_rdy;
    drn = (q.size() != 0) && wr_rdy;
    @(posedge clk);
    if (drn) tmp = q.pop_front();
    if (acc && rw) q.push_back({dr, res});
    if (acc && sf) begin
      m_n = n;
      m_z = z;
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; reg_write = 1'b0; set_flags = 1'b0;
    zero = 1'b0; negative = 1'b0; dest_reg = 4'd0; result = 32'd0;
    wb_ready = 1'b0; hz_reg = 4'd0; m_n = 1'b0; m_z = 1'b0;
    #12;
    check_val("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_hz", 32'(hz_pending), 32'd0);
    check_val("rst_flags", 32'({flag_n, flag_z}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single accept, visible one cycle later
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h0000_0005, 1'b0, 4'd0);
    check_val("t1_wb_valid", 32'(wb_valid), 32'd1);
    check_val("t1_wb_reg", 32'(wb_reg), 32'd3);
    check_val("t1_wb_data", wb_data, 32'd5);
    check_val("t1_flags", 32'({flag_n, flag_z}), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3);

    // Fill with wb_ready low, query hazards, hold a third operation
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'hAAAA_0001, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'hBBBB_0002, 1'b0, 4'd0);
    check_val("t2_in_ready", 32'(in_ready), 32'd0);
    hz_reg = 4'd2; #1;
    check_val("t2_hz2", 32'(hz_pending), 32'd1);
    hz_reg = 4'd4; #1;
    check_val("t2_hz4", 32'(hz_pending), 32'd0);
    @(negedge clk);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 32'hCCCC_0007, 1'b0, 4'd7);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 32'hCCCC_0007, 1'b0, 4'd1);
    check_val("t2_held_flags", 32'({flag_n, flag_z}), 32'd0);
    check_val("t2_held_head", 32'(wb_reg), 32'd1);

    // Full buffer: drain and accept in the same cycle
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 32'hDDDD_0005, 1'b1, 4'd5);
    check_val("t3_head", 32'(wb_reg), 32'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5);
    check_val("t3_next", 32'(wb_reg), 32'd5);
    check_val("t3_next_data", wb_data, 32'hDDDD_0005);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5);

    // Compare-type op: flags only
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 32'h1234_5678, 1'b0, 4'd9);
    check_val("t4_flag_z", 32'(flag_z), 32'd1);
    check_val("t4_flag_n", 32'(flag_n), 32'd0);
    check_val("t4_wb_valid", 32'(wb_valid), 32'd0);

    // Asynchronous reset mid-cycle with a full buffer
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 32'hEEEE_0006, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 32'hFFFF_0008, 1'b0, 4'd6);
    check_val("t5_pre_flags", 32'({flag_n, flag_z}), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check_val("t5_wb_valid", 32'(wb_valid), 32'd0);
    check_val("t5_flags", 32'({flag_n, flag_z}), 32'd0);
    check_val("t5_in_ready", 32'(in_ready), 32'd1);
    check_val("t5_hz", 32'(hz_pending), 32'd0);
    q.delete();
    m_n = 1'b0;
    m_z = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd8);

    // Random accept/drain traffic
    for (int k = 0; k < 10000; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
            1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)));
    end
    // Drain whatever is left and confirm the buffer empties
    for (int k = 0; k < DEPTH + 1; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0);
    end
    check_val("final_empty", 32'(wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
